apb2iic_arb: RTL

APB2IIC_ARB -- requirements
Module: apb2iic_arb

---
 rtl/apb2iic_arb.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/apb2iic_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb2iic_arb
//
// Shares the single APB slave port of an I2C controller between two
// requesters, one transfer at a time.  The requesters are served round-robin.
// Each transfer goes through one SETUP cycle and then ACCESS.  In ACCESS it
// either completes on PREADY or is aborted after TIMEOUT wait cycles.
// Completion is reported by a one-cycle DONEx pulse.  RDATAx and ERRx are
// valid only during that pulse.
//
// Parameters
//   TIMEOUT  maximum ACCESS cycles with PREADY=0 before the transfer aborts
//   AW / DW  address / data width
//
// Ports
//   PCLK, PRESET               clock, synchronous active-high reset
//   REQx, WRx, ADDRx, WDATAx   requester x transfer request and attributes
//   DONEx, RDATAx, ERRx        requester x completion pulse, read data, error
//   PADDR, PWDATA, PWRITE      APB transfer attributes (held for the transfer)
//   PSELx, PENABLE             APB select / enable
//   PREADY, PRDATA, PSLVERR    APB response (sampled only in ACCESS)
// ---------------------------------------------------------------------------
module apb2iic_arb #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WR0,
  input  logic          WR1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          DONE0,
  output logic          DONE1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ERR0,
  output logic          ERR1,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  output logic          PWRITE,
  output logic          PSELx,
  output logic          PENABLE,
  input  logic          PREADY,
  input  logic [DW-1:0] PRDATA,
  input  logic          PSLVERR
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_last;     // requester granted most recently
  logic          r_gnt;      // requester owning the current transfer
  logic [CW-1:0] r_wait;     // ACCESS cycles seen with PREADY=0

  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic          r_pwrite;

  logic          r_done0;
  logic          r_done1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_err0;
  logic          r_err1;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_any;
  logic          w_pick1;
  logic          w_start;
  logic          w_in_access;
  logic          w_ready;
  logic          w_tmo;
  logic          w_finish;
  logic [DW-1:0] w_rdata_cap;
  logic          w_err_cap;
  logic          w_psel;
  logic          w_penable;

  // A requester whose DONE is high this cycle is not eligible.  This keeps a
  // held REQ from being re-granted on its own completion cycle.
  assign w_elig0 = REQ0 & ~r_done0;
  assign w_elig1 = REQ1 & ~r_done1;
  assign w_any   = w_elig0 | w_elig1;

  // Requester 1 wins when it is the only one eligible, or on a tie when
  // requester 0 had the last grant.
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);

  assign w_start     = (r_state == ST_IDLE) & w_any;
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_ready     = w_in_access & PREADY;

  // PREADY wins over the timeout in the final wait cycle.
  assign w_tmo       = w_in_access & ~PREADY & (r_wait == WAIT_LAST);
  assign w_finish    = w_ready | w_tmo;

  assign w_rdata_cap = (w_ready & ~r_pwrite) ? PRDATA : '0;
  assign w_err_cap   = w_tmo | (w_ready & PSLVERR);

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and APB control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant, transfer attributes, wait counter and completion reporting
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_wait   <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;

      if (w_start) begin
        r_gnt    <= w_pick1;
        r_last   <= w_pick1;
        r_pwrite <= w_pick1 ? WR1    : WR0;
        r_paddr  <= w_pick1 ? ADDR1  : ADDR0;
        r_pwdata <= w_pick1 ? WDATA1 : WDATA0;
        r_wait   <= '0;
      end else if (w_in_access & ~PREADY & (r_wait != WAIT_MAX)) begin
        r_wait <= r_wait + CW'(1);
      end

      if (w_finish) begin
        if (r_gnt) begin
          r_done1  <= 1'b1;
          r_rdata1 <= w_rdata_cap;
          r_err1   <= w_err_cap;
        end else begin
          r_done0  <= 1'b1;
          r_rdata0 <= w_rdata_cap;
          r_err0   <= w_err_cap;
        end
      end
    end
  end

  assign DONE0   = r_done0;
  assign DONE1   = r_done1;
  assign RDATA0  = r_rdata0;
  assign RDATA1  = r_rdata1;
  assign ERR0    = r_err0;
  assign ERR1    = r_err1;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PWRITE  = r_pwrite;
  assign PSELx   = w_psel;
  assign PENABLE = w_penable;

endmodule
